qea_state_drain: RTL and testbench

QEA_STATE_DRAIN -- requirements
Module: qea_state_drain

---
 rtl/qea_pkg.sv | 19 +
 rtl/qea_amp_mag2.sv | 28 ++
 rtl/qea_state_drain.sv | 168 ++++++++++++++++
 tb/tb_qea_state_drain.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qea_pkg.sv
// Shared definitions for the QEA state-drain block: FSM states and qubit-count limits.
package qea_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } drain_state_t;

   localparam int QBIT_MIN = 2;

   // Largest drainable qubit count for a given state-RAM address width.
   function automatic int qbit_max(input int addr_w);
      return addr_w + 2;
   endfunction

endpackage

// File: rtl/qea_amp_mag2.sv
// Squared magnitude of one {real, imag} fixed-point amplitude, rescaled to the amplitude format.
// Only compiled when QEA_DRAIN_PROB_EN is defined.
`ifdef QEA_DRAIN_PROB_EN
module qea_amp_mag2 #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_FRAC_BIT = 30
) (
   input  logic [2*DATA_WIDTH-1:0] amp,
   output logic [DATA_WIDTH-1:0]   mag2
);

   localparam int SUM_W = 2*DATA_WIDTH + 1;

   logic signed [DATA_WIDTH-1:0] re;
   logic signed [DATA_WIDTH-1:0] im;
   logic signed [SUM_W-1:0]      re_x;
   logic signed [SUM_W-1:0]      im_x;
   logic signed [SUM_W-1:0]      sum;

   assign re   = amp[2*DATA_WIDTH-1:DATA_WIDTH];
   assign im   = amp[DATA_WIDTH-1:0];
   assign re_x = SUM_W'(re);
   assign im_x = SUM_W'(im);
   assign sum  = re_x*re_x + im_x*im_x;
   assign mag2 = DATA_WIDTH'(sum >>> NUM_FRAC_BIT);

endmodule
`endif

// File: rtl/qea_state_drain.sv
// Streams the QEA state RAM out one amplitude per beat, row by row, after a computation completes.
// Optional squared-magnitude output enabled by macro QEA_DRAIN_PROB_EN.
//
// state | meaning
// IDLE  | waiting for i_start
// RD    | state-RAM read of current row (o_state_ena high)
// CAP   | RAM data returns, captured into row buffer, first beat loaded
// SEND  | one amplitude per accepted beat, pe 0..PE_NUM-1
// DONE  | one-cycle o_done pulse
module qea_state_drain
   import qea_pkg::*;
#(
   parameter int PE_NUM           = 4,
   parameter int DATA_WIDTH       = 32,
   parameter int STATE_ADDR_WIDTH = 16,
   parameter int MAX_QBIT_WIDTH   = 6,
   parameter int NUM_FRAC_BIT     = 30
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_start,
   input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
   output logic                               o_state_ena,
   output logic                               o_state_wea,
   output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
   input  logic [PE_NUM*2*DATA_WIDTH-1:0]     i_state_dout,
   output logic                               o_tvalid,
   input  logic                               i_tready,
   output logic [2*DATA_WIDTH-1:0]            o_tdata,
   output logic [STATE_ADDR_WIDTH+1:0]        o_tidx,
   output logic                               o_tlast,
   output logic [DATA_WIDTH-1:0]              o_prob,
   output logic                               o_busy,
   output logic                               o_done
);

   localparam int AW     = STATE_ADDR_WIDTH;
   localparam int AMP_W  = 2*DATA_WIDTH;
   localparam logic [1:0] PE_LAST = 2'(PE_NUM - 1);

   // The basis index packs pe into two bits, so the row width must stay at four amplitudes.
   if (PE_NUM != 4 || NUM_FRAC_BIT >= AMP_W) begin : g_param_chk
      $error("qea_state_drain: PE_NUM must be 4 and NUM_FRAC_BIT below 2*DATA_WIDTH");
   end

   drain_state_t state, state_nxt;

   logic [AW-1:0]              row;
   logic [AW-1:0]              last_row;
   logic [1:0]                 pe;
   logic [1:0]                 pe_inc;
   logic [PE_NUM*AMP_W-1:0]    row_buf;
   logic [AMP_W-1:0]           tdata;
   logic [AW+1:0]              tidx;
   logic                       tlast_r;
   logic [AMP_W-1:0]           nxt_amp;
   logic [31:0]                n_ext;
   logic                       n_ok;
   logic [AW:0]                span;
   logic                       pe_end;
   logic                       beat_load;

   assign n_ext  = 32'(i_qbit_num);
   assign n_ok   = (n_ext >= 32'(QBIT_MIN)) && (n_ext <= 32'(qbit_max(AW)));
   // R-1 = 2^(n-2)-1; one spare bit keeps n = AW+2 from overflowing before the subtract.
   assign span   = ((AW+1)'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(QBIT_MIN))) - (AW+1)'(1);
   assign pe_inc = pe + 2'd1;
   assign pe_end = (pe == PE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = n_ok ? RD : DONE;
         RD:      state_nxt = CAP;
         CAP:     state_nxt = SEND;
         SEND:    if (i_tready && pe_end) state_nxt = (row == last_row) ? DONE : RD;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next amplitude to present: pe 0 straight from RAM in CAP, else the following pe from the buffer.
   always_comb begin
      nxt_amp = row_buf[int'(pe_inc)*AMP_W +: AMP_W];
      if (state == CAP) nxt_amp = i_state_dout[AMP_W-1:0];
   end

   assign beat_load = (state == CAP) || ((state == SEND) && i_tready && !pe_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row      <= '0;
         last_row <= '0;
         pe       <= '0;
         row_buf  <= '0;
         tdata    <= '0;
         tidx     <= '0;
         tlast_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start && n_ok) begin
                  row      <= '0;
                  last_row <= AW'(span);
               end
            end
            CAP: begin
               row_buf <= i_state_dout;
               pe      <= '0;
               tdata   <= nxt_amp;
               tidx    <= {row, 2'd0};
               tlast_r <= (row == last_row) && (PE_LAST == 2'd0);
            end
            SEND: begin
               if (i_tready) begin
                  if (pe_end) begin
                     if (row != last_row) row <= row + AW'(1);
                  end else begin
                     pe      <= pe_inc;
                     tdata   <= nxt_amp;
                     tidx    <= {row, pe_inc};
                     tlast_r <= (row == last_row) && (pe_inc == PE_LAST);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef QEA_DRAIN_PROB_EN
   logic [DATA_WIDTH-1:0] mag2;
   logic [DATA_WIDTH-1:0] prob_r;

   qea_amp_mag2 #(
      .DATA_WIDTH   (DATA_WIDTH),
      .NUM_FRAC_BIT (NUM_FRAC_BIT)
   ) u_mag2 (
      .amp  (nxt_amp),
      .mag2 (mag2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         prob_r <= '0;
      else if (beat_load) prob_r <= mag2;
   end

   assign o_prob = prob_r;
`else
   assign o_prob = '0;
`endif

   assign o_state_ena   = (state == RD);
   assign o_state_wea   = 1'b0;
   assign o_state_addra = row;
   assign o_tvalid      = (state == SEND);
   assign o_tdata       = tdata;
   assign o_tidx        = tidx;
   assign o_tlast       = (state == SEND) && tlast_r;
   assign o_busy        = (state == RD) || (state == CAP) || (state == SEND);
   assign o_done        = (state == DONE);

endmodule

// File: tb/tb_qea_state_drain.sv
// Self-checking bench for qea_state_drain: table of drain requests against a reference beat model,
// plus reset-abort and REQ-style corner sequences.
module tb_qea_state_drain;

   localparam int PE_NUM = 4;
   localparam int DW     = 32;
   localparam int AW     = 16;
   localparam int QW     = 6;
   localparam int NFB    = 30;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_start = 1'b0;
   logic [QW-1:0]     i_qbit_num = '0;
   logic              o_state_ena;
   logic              o_state_wea;
   logic [AW-1:0]     o_state_addra;
   logic [PE_NUM*2*DW-1:0] i_state_dout = '0;
   logic              o_tvalid;
   logic              i_tready = 1'b1;
   logic [2*DW-1:0]   o_tdata;
   logic [AW+1:0]     o_tidx;
   logic              o_tlast;
   logic [DW-1:0]     o_prob;
   logic              o_busy;
   logic              o_done;

   qea_state_drain #(
      .PE_NUM(PE_NUM), .DATA_WIDTH(DW), .STATE_ADDR_WIDTH(AW),
      .MAX_QBIT_WIDTH(QW), .NUM_FRAC_BIT(NFB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_qbit_num(i_qbit_num),
      .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
      .i_state_dout(i_state_dout), .o_tvalid(o_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tidx(o_tidx), .o_tlast(o_tlast), .o_prob(o_prob),
      .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW+1:0]   idx;
      logic [2*DW-1:0] data;
      logic            last;
      logic [DW-1:0]   prob;
   } beat_t;

   typedef struct {
      int n;
      bit rnd;
      bit restart;
      int beats;
      int rows;
      int done_lat;
   } vec_t;

   logic [PE_NUM*2*DW-1:0] mem [0:63];
   beat_t got_q[$];
   beat_t exp_q[$];
   int    addr_q[$];
   int    first_valid, done_cyc, done_cnt;
   bit    rnd_ready = 1'b0;
   int    checks = 0;
   int    failures = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // State RAM with one-cycle read latency.
   initial begin
      logic          en;
      logic [AW-1:0] a;
      forever begin
         @(negedge clk);
         en = o_state_ena;
         a  = o_state_addra;
         @(posedge clk);
         #1;
         if (en) i_state_dout = mem[a[5:0]];
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         i_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: collects accepted beats and checks stability under back-pressure.
   initial begin
      bit    stall_prev;
      beat_t held, cur;
      stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            cur.idx = o_tidx; cur.data = o_tdata; cur.last = o_tlast; cur.prob = o_prob;
            if (stall_prev) begin
               check("hold_valid", 64'(o_tvalid), 64'd1);
               check("hold_data",  o_tdata, held.data);
               check("hold_idx",   64'(o_tidx), 64'(held.idx));
               check("hold_last",  64'(o_tlast), 64'(held.last));
               check("hold_prob",  64'(o_prob), 64'(held.prob));
            end
            if (o_tvalid) begin
               check("busy_in_send", 64'(o_busy), 64'd1);
               if (first_valid < 0) first_valid = cyc;
               if (i_tready) got_q.push_back(cur);
            end
            if (o_state_ena) begin
               check("wea_zero", 64'(o_state_wea), 64'd0);
               addr_q.push_back(int'(o_state_addra));
            end
            if (o_done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            stall_prev = o_tvalid && !i_tready;
            held = cur;
         end
      end
   end

   // Reference: the full basis sweep, amplitude idx taken from RAM row idx/4, slot idx%4.
   task automatic build_exp(input int n);
      exp_q.delete();
      if (n >= 2 && n <= AW + 2) begin
         int total = PE_NUM * (1 << (n - 2));
         for (int i = 0; i < total; i++) begin
            beat_t b;
            logic [PE_NUM*2*DW-1:0] w;
            logic signed [DW-1:0] re, im;
            logic signed [2*DW:0] s;
            w = mem[i / PE_NUM];
            b.data = w[(i % PE_NUM)*2*DW +: 2*DW];
            b.idx  = (AW+2)'(i);
            b.last = (i == total - 1);
            re = b.data[2*DW-1:DW];
            im = b.data[DW-1:0];
            s  = (2*DW+1)'(re) * (2*DW+1)'(re) + (2*DW+1)'(im) * (2*DW+1)'(im);
`ifdef QEA_DRAIN_PROB_EN
            b.prob = DW'(s >>> NFB);
`else
            b.prob = (s == s) ? '0 : '1;
`endif
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      addr_q.delete();
      first_valid = -1;
      done_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic run_drain(input vec_t v);
      int c0, ncmp;
      clear_mon();
      build_exp(v.n);
      rnd_ready = v.rnd;
      @(posedge clk); #1;
      i_qbit_num = QW'(v.n);
      i_start = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      i_start = 1'b0;
      if (v.restart) begin
         repeat (4) @(posedge clk);
         #1;
         i_qbit_num = QW'(2);
         i_start = 1'b1;
         @(posedge clk); #1;
         i_start = 1'b0;
      end
      for (int k = 0; k < 20000 && done_cnt == 0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      rnd_ready = 1'b0;
      check("done_count", 64'(done_cnt), 64'd1);
      check("busy_after_done", 64'(o_busy), 64'd0);
      check("beat_count", 64'(got_q.size()), 64'(v.beats));
      ncmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < ncmp; i++) begin
         check("beat_idx",  64'(got_q[i].idx),  64'(exp_q[i].idx));
         check("beat_data", got_q[i].data,      exp_q[i].data);
         check("beat_last", 64'(got_q[i].last), 64'(exp_q[i].last));
         check("beat_prob", 64'(got_q[i].prob), 64'(exp_q[i].prob));
      end
      check("row_reads", 64'(addr_q.size()), 64'(v.rows));
      for (int i = 0; i < addr_q.size(); i++) check("row_addr", 64'(addr_q[i]), 64'(i));
      if (v.beats > 0) check("first_valid_lat", 64'(first_valid - c0), 64'd3);
      else             check("no_valid", 64'(first_valid), 64'(-1));
      if (v.done_lat >= 0) check("done_lat", 64'(done_cyc - c0), 64'(v.done_lat));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ena"},   64'(o_state_ena),   64'd0);
      check({tag, "_wea"},   64'(o_state_wea),   64'd0);
      check({tag, "_addr"},  64'(o_state_addra), 64'd0);
      check({tag, "_valid"}, 64'(o_tvalid),      64'd0);
      check({tag, "_data"},  o_tdata,            64'd0);
      check({tag, "_idx"},   64'(o_tidx),        64'd0);
      check({tag, "_last"},  64'(o_tlast),       64'd0);
      check({tag, "_prob"},  64'(o_prob),        64'd0);
      check({tag, "_busy"},  64'(o_busy),        64'd0);
      check({tag, "_done"},  64'(o_done),        64'd0);
   endtask

   initial begin
      vec_t vecs[$];
      vec_t v0;
      bit   found;
      logic [DW-1:0] exp_p;

      vecs.push_back('{n: 5,  rnd: 0, restart: 0, beats: 32,  rows: 8,  done_lat: 49});
      vecs.push_back('{n: 2,  rnd: 0, restart: 0, beats: 4,   rows: 1,  done_lat: 7});
      vecs.push_back('{n: 1,  rnd: 0, restart: 0, beats: 0,   rows: 0,  done_lat: 1});
      vecs.push_back('{n: 19, rnd: 0, restart: 0, beats: 0,   rows: 0,  done_lat: 1});
      vecs.push_back('{n: 0,  rnd: 0, restart: 0, beats: 0,   rows: 0,  done_lat: 1});
      vecs.push_back('{n: 4,  rnd: 0, restart: 0, beats: 16,  rows: 4,  done_lat: 25});
      vecs.push_back('{n: 5,  rnd: 1, restart: 0, beats: 32,  rows: 8,  done_lat: -1});
      vecs.push_back('{n: 3,  rnd: 0, restart: 1, beats: 8,   rows: 2,  done_lat: 13});
      vecs.push_back('{n: 7,  rnd: 1, restart: 1, beats: 128, rows: 32, done_lat: -1});

      for (int r = 0; r < 64; r++) mem[r] = '0;
      mem[0][4*2*DW-1 -: 2*DW] = {32'h4000_0000, 32'h0};

      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single non-zero amplitude at basis index 3.
      v0 = vecs[0];
      run_drain(v0);
`ifdef QEA_DRAIN_PROB_EN
      exp_p = 32'h4000_0000;
`else
      exp_p = 32'h0;
`endif
      if (got_q.size() == 32) begin
         check("pe3_data", got_q[3].data, 64'h4000_0000_0000_0000);
         check("pe3_prob", 64'(got_q[3].prob), 64'(exp_p));
         check("idx30_last", 64'(got_q[30].last), 64'd0);
         check("idx31_last", 64'(got_q[31].last), 64'd1);
      end

      for (int r = 0; r < 64; r++)
         for (int w = 0; w < 2*PE_NUM; w++) mem[r][w*DW +: DW] = $urandom;

      for (int i = 1; i < vecs.size(); i++) run_drain(vecs[i]);

      // Abort mid-drain during row 3, then drain again cleanly.
      clear_mon();
      @(posedge clk); #1;
      i_qbit_num = QW'(5);
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (o_state_ena && o_state_addra == AW'(3)) found = 1'b1;
      end
      check("reached_row3", 64'(found), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("no_done_after_abort", 64'(done_cnt), 64'd0);
      run_drain('{n: 3, rnd: 0, restart: 0, beats: 8, rows: 2, done_lat: 13});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
